// File: rtl/ara_scoreboard.sv
// ara_scoreboard: tracks in-flight vector instructions per PE, allocates
// instruction IDs and computes RAW/WAR/WAW dependency vectors at issue.
module ara_scoreboard #(
  parameter  int unsigned NrPEs   = 8,
  parameter  int unsigned NrVInsn = 8,
  parameter  int unsigned NrVRegs = 32,
  localparam int unsigned IdW     = $clog2(NrVInsn),
  localparam int unsigned RegW    = $clog2(NrVRegs)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  logic [RegW-1:0]                  req_vs1_i,
  input  logic [RegW-1:0]                  req_vs2_i,
  input  logic [RegW-1:0]                  req_vd_i,
  input  logic                             req_use_vs1_i,
  input  logic                             req_use_vs2_i,
  input  logic                             req_use_vd_i,
  input  logic                             req_use_vd_op_i,
  input  logic                             req_vm_i,
  input  logic [NrPEs-1:0]                 req_pe_mask_i,
  output logic                             issue_valid_o,
  input  logic                             issue_ready_i,
  output logic [IdW-1:0]                   issue_id_o,
  output logic [NrVInsn-1:0]               issue_hazard_vs1_o,
  output logic [NrVInsn-1:0]               issue_hazard_vs2_o,
  output logic [NrVInsn-1:0]               issue_hazard_vm_o,
  output logic [NrVInsn-1:0]               issue_hazard_vd_o,
  input  logic [NrPEs-1:0][NrVInsn-1:0]    pe_done_i,
  output logic [NrVInsn-1:0]               vinsn_running_o,
  output logic [IdW:0]                     inflight_cnt_o,
  output logic                             idle_o
);

  localparam int unsigned CntW = IdW + 1;

  logic [NrPEs-1:0][NrVInsn-1:0]   pe_run_q, pe_run_d;
  logic [NrVInsn-1:0]              running_q, running_d;
  logic [NrVRegs-1:0][IdW-1:0]     owner_id_q, owner_id_d;
  logic [NrVRegs-1:0]              owner_vld_q, owner_vld_d, owner_vld_c;
  logic [NrVRegs-1:0][NrVInsn-1:0] readers_q, readers_d, readers_c;
  logic                            full_c;
  logic [IdW-1:0]                  alloc_id_c;
  logic [NrVInsn-1:0]              alloc_oh_c;
  logic [NrVInsn-1:0]              hz_vs1_c, hz_vs2_c, hz_vm_c, hz_vd_c;
  logic                            operandless_c, stall_c, accept_c;
  logic [CntW-1:0]                 cnt_c;

  function automatic logic [NrVInsn-1:0] id_onehot(input logic [IdW-1:0] id);
    logic [NrVInsn-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

  assign vinsn_running_o = running_q;

  // Lowest free ID; full when every ID is running.
  always_comb begin
    alloc_id_c = '0;
    for (int i = int'(NrVInsn) - 1; i >= 0; i--) begin
      if (!running_q[i]) alloc_id_c = IdW'(i);
    end
    full_c     = &running_q;
    alloc_oh_c = id_onehot(alloc_id_c);
  end

  // Drop owner/reader entries whose instruction is no longer running.
  always_comb begin
    owner_vld_c = '0;
    readers_c   = '0;
    for (int unsigned r = 0; r < NrVRegs; r++) begin
      owner_vld_c[r] = owner_vld_q[r] & running_q[owner_id_q[r]];
      readers_c[r]   = readers_q[r] & running_q;
    end
  end

  // Dependency vectors for the current request and operand-less stall.
  always_comb begin
    hz_vs1_c = '0;
    hz_vs2_c = '0;
    hz_vm_c  = '0;
    hz_vd_c  = '0;
    if (req_use_vs1_i && owner_vld_c[req_vs1_i]) hz_vs1_c = id_onehot(owner_id_q[req_vs1_i]);
    if (req_use_vs2_i && owner_vld_c[req_vs2_i]) hz_vs2_c = id_onehot(owner_id_q[req_vs2_i]);
    if (!req_vm_i && owner_vld_c[0]) hz_vm_c = id_onehot(owner_id_q[0]);
    if (req_use_vd_i) begin
      hz_vd_c = readers_c[req_vd_i];
      if (owner_vld_c[req_vd_i]) hz_vd_c = hz_vd_c | id_onehot(owner_id_q[req_vd_i]);
    end
    operandless_c = !req_use_vs1_i && !req_use_vs2_i && !req_use_vd_op_i && req_vm_i;
    stall_c       = operandless_c && (|(hz_vs1_c | hz_vs2_c | hz_vm_c | hz_vd_c));
  end

  assign req_ready_o = !rst_i && !full_c && (!issue_valid_o || issue_ready_i) && !stall_c;
  assign accept_c    = req_valid_i && req_ready_o;

  // Per-PE running matrix: completions clear, acceptance sets (set wins).
  always_comb begin
    pe_run_d  = '0;
    running_d = '0;
    for (int unsigned p = 0; p < NrPEs; p++) begin
      pe_run_d[p] = pe_run_q[p] & ~pe_done_i[p];
      if (accept_c && (req_pe_mask_i[p] || ((p == NrPEs - 1) && !req_vm_i)))
        pe_run_d[p] = pe_run_d[p] | alloc_oh_c;
      running_d = running_d | pe_run_d[p];
    end
  end

  // Owner/reader list update on top of the cleaned lists.
  always_comb begin
    owner_id_d  = owner_id_q;
    owner_vld_d = owner_vld_c;
    readers_d   = readers_c;
    if (accept_c) begin
      if (req_use_vd_i) begin
        owner_id_d[req_vd_i]  = alloc_id_c;
        owner_vld_d[req_vd_i] = 1'b1;
      end
      if (req_use_vs1_i) readers_d[req_vs1_i] = readers_d[req_vs1_i] | alloc_oh_c;
      if (req_use_vs2_i) readers_d[req_vs2_i] = readers_d[req_vs2_i] | alloc_oh_c;
      if (!req_vm_i)     readers_d[0]         = readers_d[0] | alloc_oh_c;
    end
  end

  // Population count of the next running set.
  always_comb begin
    cnt_c = '0;
    for (int unsigned i = 0; i < NrVInsn; i++) cnt_c = cnt_c + CntW'(running_d[i]);
  end

  // Tracking state and status outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pe_run_q       <= '0;
      running_q      <= '0;
      owner_id_q     <= '0;
      owner_vld_q    <= '0;
      readers_q      <= '0;
      inflight_cnt_o <= '0;
      idle_o         <= 1'b1;
    end else begin
      pe_run_q       <= pe_run_d;
      running_q      <= running_d;
      owner_id_q     <= owner_id_d;
      owner_vld_q    <= owner_vld_d;
      readers_q      <= readers_d;
      inflight_cnt_o <= cnt_c;
      idle_o         <= ~|running_d;
    end
  end

  // Issue register; held hazards shrink as their producers complete.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      issue_valid_o      <= 1'b0;
      issue_id_o         <= '0;
      issue_hazard_vs1_o <= '0;
      issue_hazard_vs2_o <= '0;
      issue_hazard_vm_o  <= '0;
      issue_hazard_vd_o  <= '0;
    end else if (accept_c) begin
      issue_valid_o      <= 1'b1;
      issue_id_o         <= alloc_id_c;
      issue_hazard_vs1_o <= hz_vs1_c & running_d;
      issue_hazard_vs2_o <= hz_vs2_c & running_d;
      issue_hazard_vm_o  <= hz_vm_c & running_d;
      issue_hazard_vd_o  <= hz_vd_c & running_d;
    end else if (issue_valid_o && issue_ready_i) begin
      issue_valid_o <= 1'b0;
    end else if (issue_valid_o) begin
      issue_hazard_vs1_o <= issue_hazard_vs1_o & running_d;
      issue_hazard_vs2_o <= issue_hazard_vs2_o & running_d;
      issue_hazard_vm_o  <= issue_hazard_vm_o & running_d;
      issue_hazard_vd_o  <= issue_hazard_vd_o & running_d;
    end
  end

  // A request must target at least one PE unless it is masked.
  assert property (@(posedge clk_i) disable iff (rst_i)
    req_valid_i |-> ((req_pe_mask_i != '0) || !req_vm_i));

endmodule
